// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO drain block: default word width and the
// width of the completed-transfer counter.
package fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int WORDS_W        = 16;
endpackage

// File: rtl/fifo_drain_skid_buf2.sv
// Two-entry FIFO-ordered store. The head word and the valid flag are plain
// registers so the stream outputs come straight from flops.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          valid_o,
    output logic [1:0]    occ_o
);
    logic [DW-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]    occ_q, occ_d;
    logic          valid_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) head_d = din_i;
                else               tail_d = din_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged: drop the head, append the new word.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = din_i;
                end else begin
                    head_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= (occ_d != 2'd0);
        end
    end

    assign dout_o  = head_q;
    assign valid_o = valid_q;
    assign occ_o   = occ_q;
endmodule

// File: rtl/fifo_drain.sv
// Drains a registered-output FIFO into a valid/ready stream with credit-based
// read issue so the 2-entry store can never overflow.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_valid,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORDS_W-1:0]    words_out
);
    logic               inflight_q, armed_q;
    logic [1:0]         occ;
    logic               pop;
    logic [2:0]         credit;
    logic [WORDS_W-1:0] words_q, words_d;

    skid_buf2 #(.DW(DATA_WIDTH)) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_valid),
        .din_i   (fifo_dout),
        .pop_i   (pop),
        .dout_o  (m_data),
        .valid_o (m_valid),
        .occ_o   (occ)
    );

    assign pop    = m_valid & m_ready;
    assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    // armed_q is cleared asynchronously and only sets on the first edge after
    // release, which also keeps the strobe low throughout reset.
    assign fifo_rd_en = armed_q & drain_en & ~fifo_empty & (credit < 3'd2);
    assign words_d    = pop ? words_q + WORDS_W'(1) : words_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            armed_q    <= 1'b0;
            words_q    <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            armed_q    <= 1'b1;
            words_q    <= words_d;
        end
    end

    assign words_out = words_q;
endmodule

// File: tb/tb_fifo_drain.sv
// Randomized and directed bench for fifo_drain against a FIFO model and a
// transaction-level scoreboard (word order, availability, credit, counter).
module tb_fifo_drain;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          drain_en = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_empty, fifo_valid, fifo_rd_en, m_valid;
    logic [DW-1:0] fifo_dout, m_data;
    logic [15:0]   words_out;

    always #5 clk = ~clk;

    fifo_drain #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .drain_en   (drain_en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_valid (fifo_valid),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .words_out  (words_out)
    );

    // Paired FIFO: registered read data, valid one cycle after the strobe,
    // flushed by the shared reset. Garbage on dout when not valid.
    logic [DW-1:0] fmem [1024];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_valid <= 1'b0;
            fifo_dout  <= '0;
            rd_ptr     <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_valid <= 1'b1;
            fifo_dout  <= fmem[rd_ptr % 1024];
            rd_ptr     <= rd_ptr + 1;
        end else begin
            fifo_valid <= 1'b0;
            fifo_dout  <= DW'($urandom);
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        fmem[wr_ptr % 1024] = d;
        wr_ptr++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: words come out in FIFO order; a word is presentable once
    // captured and not yet popped; reads are issued only with credit.
    logic        tb_armed;
    int          cap = 0, popc = 0, xfer_total = 0;
    logic        infl = 1'b0, prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [15:0] expw = '0;
    int unsigned exp_ptr = 0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_armed <= 1'b0;
        else        tb_armed <= 1'b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            cap = 0; popc = 0; infl = 1'b0; expw = '0;
            exp_ptr = wr_ptr; prev_stall = 1'b0; xfer_total = 0;
        end else begin
            int  avail;
            logic popn, exp_rd;
            avail  = cap - popc;
            chk("m_valid", m_valid, avail > 0);
            popn   = m_valid && m_ready;
            exp_rd = tb_armed && drain_en && !fifo_empty
                     && (avail + int'(infl) - int'(popn) < 2);
            chk("rd_en", fifo_rd_en, exp_rd);
            chk("words_out", words_out, expw);
            if (prev_stall) chk("hold_data", m_data, prev_data);
            if (popn) begin
                chk("data", m_data, fmem[exp_ptr % 1024]);
                exp_ptr++;
                expw = expw + 16'd1;
                xfer_total++;
            end
            cap  += int'(fifo_valid);
            popc += int'(popn);
            infl = fifo_rd_en;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    int            rd_n, xf_n, first_rd;
    int            xs [16];
    logic [DW-1:0] xd [16];

    task automatic observe(input int n);
        rd_n = 0; xf_n = 0; first_rd = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (fifo_rd_en) begin
                if (first_rd < 0) first_rd = i;
                rd_n++;
            end
            if (m_valid && m_ready) begin
                if (xf_n < 16) begin
                    xs[xf_n] = i;
                    xd[xf_n] = m_data;
                end
                xf_n++;
            end
        end
    endtask

    logic [DW-1:0] words [5];
    logic [15:0]   w0;
    int            guard;

    initial begin
        // Reset state with drain requested.
        drain_en = 1'b1; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_words", words_out, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        wr(8'hA5);
        #1;
        chk("no_rd_before_edge", fifo_rd_en, 0);
        observe(6);
        chk("first_word_xf", xf_n, 1);
        chk("first_word_data", xd[0], 8'hA5);

        // Three preloaded words stream back-to-back, 2 cycles after first read.
        step();
        drain_en = 1'b0;
        wr(8'h11); wr(8'h22); wr(8'h33);
        w0 = words_out;
        step();
        drain_en = 1'b1;
        observe(10);
        chk("a_xf", xf_n, 3);
        chk("a_lat", xs[0], first_rd + 2);
        chk("a_gap1", xs[1], first_rd + 3);
        chk("a_gap2", xs[2], first_rd + 4);
        chk("a_d0", xd[0], 8'h11);
        chk("a_d1", xd[1], 8'h22);
        chk("a_d2", xd[2], 8'h33);
        chk("a_words", words_out, w0 + 16'd3);

        // Stalled downstream: only two reads, head word held, then full drain.
        step();
        m_ready = 1'b0; drain_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            words[i] = DW'($urandom);
            wr(words[i]);
        end
        step();
        drain_en = 1'b1;
        observe(10);
        chk("b_rd_pulses", rd_n, 2);
        chk("b_m_valid", m_valid, 1);
        chk("b_head", m_data, words[0]);
        step();
        m_ready = 1'b1;
        observe(10);
        chk("b_xf", xf_n, 5);
        chk("b_nogap", xs[4] - xs[0], 4);
        for (int i = 0; i < 5; i++) chk("b_order", xd[i], words[i]);

        // Single word: one read, one output cycle.
        step();
        wr(8'h5C);
        observe(8);
        chk("c_rd_pulses", rd_n, 1);
        chk("c_xf", xf_n, 1);

        // drain_en dropped after one read: in-flight word still delivered.
        step();
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            words[i] = DW'($urandom);
            wr(words[i]);
        end
        step();
        drain_en = 1'b1;
        step();
        drain_en = 1'b0;
        observe(8);
        chk("d_rd_pulses", rd_n, 0);
        chk("d_xf", xf_n, 1);
        chk("d_data", xd[0], words[0]);
        step();
        drain_en = 1'b1;
        observe(10);
        chk("d_rest_xf", xf_n, 3);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            step();
            drain_en = ($urandom_range(0, 3) != 0);
            m_ready  = ($urandom_range(0, 2) != 0);
            if ((wr_ptr - rd_ptr) < 32 && $urandom_range(0, 1) == 1) wr(DW'($urandom));
        end
        step();
        drain_en = 1'b1; m_ready = 1'b1;
        guard = 0;
        while ((!fifo_empty || m_valid || fifo_valid) && guard < 200) begin
            step();
            guard++;
        end
        chk("rand_drained", guard < 200, 1);

        // Asynchronous reset mid-stream with the store full.
        step();
        m_ready = 1'b0; drain_en = 1'b1;
        for (int i = 0; i < 4; i++) wr(DW'($urandom));
        observe(6);
        chk("e_pre_valid", m_valid, 1);
        chk("e_pre_words", words_out != 16'd0, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("e_rst_valid", m_valid, 0);
        chk("e_rst_rd", fifo_rd_en, 0);
        chk("e_rst_words", words_out, 0);
        chk("e_rst_data", m_data, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            words[i] = DW'($urandom);
            wr(words[i]);
        end
        observe(10);
        chk("e_xf", xf_n, 4);
        for (int i = 0; i < 4; i++) chk("e_order", xd[i], words[i]);
        chk("e_words", words_out, 4);

        // Counter wrap: 65537 transfers from reset leaves words_out at 1.
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        step();
        drain_en = 1'b1; m_ready = 1'b1;
        begin
            int written;
            written = 0;
            guard = 0;
            while (xfer_total < 65537 && guard < 70000) begin
                step();
                guard++;
                if (written < 65537 && (wr_ptr - rd_ptr) < 8) begin
                    wr(DW'($urandom));
                    written++;
                end
            end
        end
        chk("wrap_done", xfer_total, 65537);
        chk("wrap_words", words_out, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each FIFO word and output data.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port drain_en  input  1  permits new FIFO reads when high.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port fifo_dout  input  DATA_WIDTH  FIFO registered read data.
REQ-007 SHALL have port fifo_valid  input  1  high one cycle after each FIFO read strobe; qualifies fifo_dout.
REQ-008 SHALL have port fifo_rd_en  output  1  FIFO read strobe.
REQ-009 SHALL have port m_data  output  DATA_WIDTH  output stream data.
REQ-010 SHALL have port m_valid  output  1  m_data holds a word.
REQ-011 SHALL have port m_ready  input  1  downstream accepts; transfer when m_valid and m_ready both high.
REQ-012 SHALL have port words_out  output  16  count of completed output transfers.

Function
REQ-013 SHALL buffer up to 2 words in an internal FIFO-ordered store; occ = buffered words (0..2).
REQ-014 SHALL track inflight (0/1) = fifo_rd_en was high in the previous cycle.
REQ-015 SHALL drive fifo_rd_en combinationally = drain_en and not fifo_empty and (occ + inflight - pop) < 2, where pop = m_valid and m_ready.
REQ-016 SHALL never assert fifo_rd_en while fifo_empty is high, whatever the other inputs.
REQ-017 SHALL capture fifo_dout into the store on every cycle fifo_valid is high; the credit rule guarantees space, and overflow never occurs.
REQ-018 SHALL drive m_valid = (occ > 0) and m_data = oldest buffered word, both directly from registers.
REQ-019 SHALL hold m_data stable while m_valid is high and m_ready is low.
REQ-020 SHALL, on simultaneous capture and pop, remove the oldest word and append the new one, leaving occ unchanged.
REQ-021 SHALL sustain one word per cycle once primed, with fifo_empty low, m_ready high and drain_en high.
REQ-022 SHALL have minimum latency fifo_rd_en -> m_valid of 2 cycles: fifo_valid at t+1, m_valid at t+2.
REQ-023 SHALL, when drain_en deasserts, issue no new reads, still capture any inflight word, and keep presenting buffered words.
REQ-024 SHALL increment words_out by 1 per pop, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL ignore fifo_dout whenever fifo_valid is low.

Reset
REQ-026 SHALL, on rst_n low (asynchronous), force occ=0, inflight=0, words_out=0, m_valid=0, m_data=0, and fifo_rd_en=0 combinationally.
REQ-027 SHALL discard any inflight word after reset release; the paired FIFO resets from the same rst_n.
REQ-028 SHALL issue no fifo_rd_en before the first rising clk edge after rst_n goes high.

Structure
REQ-029 SHALL place the DATA_WIDTH default and the words_out width (16) as constants in shared package fifo_pkg.
REQ-030 SHALL implement the 2-entry store as sub-module skid_buf2 (push, pop, data in/out, occ); fifo_drain holds credit, inflight and counter logic.

Verification
REQ-031 SHALL verify: FIFO preloaded with 0x11,0x22,0x33, m_ready=1, drain_en=1 -> m_data 0x11,0x22,0x33 on three consecutive cycles starting 2 cycles after first fifo_rd_en; words_out=3.
REQ-032 SHALL verify: FIFO holds 5 words, m_ready=0 -> exactly 2 fifo_rd_en pulses, m_valid=1, m_data=first word held stable; m_ready=1 then drains all 5 in order with no gaps.
REQ-033 SHALL verify: FIFO holds 1 word -> single fifo_rd_en pulse, never asserted with fifo_empty=1; m_valid high for exactly 1 cycle with m_ready=1.
REQ-034 SHALL verify: drain_en dropped the cycle after a fifo_rd_en -> inflight word still output; no further fifo_rd_en until drain_en=1.
REQ-035 SHALL verify: rst_n pulsed low mid-stream with occ=2 -> m_valid, fifo_rd_en and words_out go 0 immediately without a clock; after release, streaming restarts cleanly from freshly written data.
REQ-036 SHALL verify: 65537 transfers -> words_out wraps to 0x0001.
